// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the CPU/DMA RAM arbiter.
package ram_arbiter_pkg;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned STREAK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  // Latched copy of the granted master's request
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive CPU grants taken while DMA waits; flags when DMA must win.
module arb_starve_counter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned CPU_MAX_STREAK = 4
) (
  input  logic clk,
  input  logic nreset,
  input  logic grant_cpu_i,
  input  logic grant_dma_i,
  input  logic dma_req_i,
  output logic force_dma_o
);

  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(CPU_MAX_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                force_dma_q;

  // Clear on DMA grant or uncontested CPU grant, saturating count otherwise
  always_comb begin
    streak_d = streak_q;
    if (grant_dma_i) begin
      streak_d = '0;
    end else if (grant_cpu_i) begin
      if (!dma_req_i) begin
        streak_d = '0;
      end else if (streak_q >= MAX_STREAK) begin
        streak_d = MAX_STREAK;
      end else begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      streak_q    <= '0;
      force_dma_q <= 1'b0;
    end else begin
      streak_q    <= streak_d;
      force_dma_q <= (streak_d == MAX_STREAK);
    end
  end

  assign force_dma_o = force_dma_q;

endmodule

// File: rtl/ram_arbiter.sv
// Shares one 8-bit RAM between CPU (priority) and DMA using fixed
// three-cycle IDLE/ACCESS/DONE transactions with a DMA anti-starvation limit.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned CPU_MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_we,
  output logic              ram_oe,
  output logic              busy,
  output logic              owner
);

  state_e              state_q, state_d;
  ram_req_t            req_q, req_d;
  logic                owner_q, owner_d;
  logic                ram_we_q, ram_we_d;
  logic                ram_oe_q, ram_oe_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                dma_ack_q, dma_ack_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic                grant_cpu_c, grant_dma_c;
  logic                force_dma;

  arb_starve_counter #(
    .CPU_MAX_STREAK(CPU_MAX_STREAK)
  ) u_starve (
    .clk        (clk),
    .nreset     (nreset),
    .grant_cpu_i(grant_cpu_c),
    .grant_dma_i(grant_dma_c),
    .dma_req_i  (dma_req),
    .force_dma_o(force_dma)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    owner_d     = owner_q;
    ram_we_d    = 1'b0;
    ram_oe_d    = 1'b0;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    busy_d      = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    grant_cpu_c = 1'b0;
    grant_dma_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (dma_req && (!cpu_req || force_dma)) begin
          grant_dma_c = 1'b1;
          req_d       = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};
          owner_d     = OWN_DMA;
          ram_we_d    = dma_we;
          ram_oe_d    = !dma_we;
          state_d     = ST_ACCESS;
        end else if (cpu_req) begin
          grant_cpu_c = 1'b1;
          req_d       = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
          owner_d     = OWN_CPU;
          ram_we_d    = cpu_we;
          ram_oe_d    = !cpu_we;
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Read data is captured on the edge that closes ACCESS
        if (!req_q.we) begin
          if (owner_q == OWN_CPU) cpu_rdata_d = ram_rdata;
          else                    dma_rdata_d = ram_rdata;
        end
        if (owner_q == OWN_CPU) cpu_ack_d = 1'b1;
        else                    dma_ack_d = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      owner_q     <= OWN_CPU;
      ram_we_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      owner_q     <= owner_d;
      ram_we_q    <= ram_we_d;
      ram_oe_q    <= ram_oe_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      busy_q      <= busy_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign ram_addr  = req_q.addr;
  assign ram_wdata = req_q.wdata;
  assign ram_we    = ram_we_q;
  assign ram_oe    = ram_oe_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: cycle vector table plus hand-written
// sequences for arbitration fairness, DMA-only access and mid-access reset.
module tb_ram_arbiter;

  logic       clk;
  logic       nreset;
  logic       cpu_req, cpu_we, dma_req, dma_we;
  logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [7:0] cpu_rdata, dma_rdata;
  logic       cpu_ack, dma_ack;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       ram_we, ram_oe, busy, owner;

  int n_vec  = 0;
  int n_miss = 0;

  ram_arbiter #(.CPU_MAX_STREAK(4)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack  (cpu_ack),
    .dma_req  (dma_req),
    .dma_we   (dma_we),
    .dma_addr (dma_addr),
    .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata),
    .dma_ack  (dma_ack),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .ram_we   (ram_we),
    .ram_oe   (ram_oe),
    .busy     (busy),
    .owner    (owner)
  );

  // RAM model: combinational read, write on rising edge
  logic [7:0] mem [256] = '{1: 8'h11, 2: 8'h22, default: 8'h00};
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] cflags;   // {req, we}
    logic [7:0] caddr;
    logic [7:0] cwd;
    logic [1:0] dflags;
    logic [7:0] daddr;
    logic [7:0] dwd;
    logic [29:0] exp;     // {cack,dack,busy,owner,ram_we,ram_oe,ram_addr,cpu_rdata,dma_rdata}
  } vec_t;

  function automatic vec_t mkv(input logic [1:0] cf, input logic [7:0] ca, input logic [7:0] cw,
                               input logic [1:0] df, input logic [7:0] da, input logic [7:0] dw,
                               input logic [5:0] fl, input logic [7:0] ra, input logic [7:0] crd,
                               input logic [7:0] drd);
    vec_t v;
    v.cflags = cf; v.caddr = ca; v.cwd = cw;
    v.dflags = df; v.daddr = da; v.dwd = dw;
    v.exp = {fl, ra, crd, drd};
    return v;
  endfunction

  function automatic logic [29:0] outs();
    return {cpu_ack, dma_ack, busy, owner, ram_we, ram_oe, ram_addr, cpu_rdata, dma_rdata};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bounded wait for the next ack; a double ack or timeout is a miscompare
  task automatic wait_ack(input string nm, output logic c, output logic d);
    bit found = 1'b0;
    c = 1'b0;
    d = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(posedge clk);
      #1;
      if (cpu_ack && dma_ack) chk({nm, "_double_ack"}, 32'({cpu_ack, dma_ack}), 32'h1);
      if (cpu_ack || dma_ack) begin
        c = cpu_ack;
        d = dma_ack;
        found = 1'b1;
      end
    end
    if (!found) chk({nm, "_timeout"}, 32'h0, 32'h1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[20];
  logic c, d;

  initial begin
    // Table: test-plan items 1, 6 and 4 cycle by cycle (state after each edge)
    tbl[0]  = mkv(2'b11, 8'h10, 8'hA5, 2'b00, 8'h00, 8'h00, 6'b001010, 8'h10, 8'h00, 8'h00);
    tbl[1]  = mkv(2'b11, 8'h10, 8'hA5, 2'b00, 8'h00, 8'h00, 6'b101000, 8'h10, 8'h00, 8'h00);
    tbl[2]  = mkv(2'b11, 8'h10, 8'hA5, 2'b00, 8'h00, 8'h00, 6'b000000, 8'h10, 8'h00, 8'h00);
    tbl[3]  = mkv(2'b10, 8'h10, 8'h00, 2'b00, 8'h00, 8'h00, 6'b001001, 8'h10, 8'h00, 8'h00);
    tbl[4]  = mkv(2'b10, 8'h10, 8'h00, 2'b00, 8'h00, 8'h00, 6'b101000, 8'h10, 8'hA5, 8'h00);
    tbl[5]  = mkv(2'b10, 8'h10, 8'h00, 2'b00, 8'h00, 8'h00, 6'b000000, 8'h10, 8'hA5, 8'h00);
    tbl[6]  = mkv(2'b00, 8'h10, 8'h00, 2'b00, 8'h00, 8'h00, 6'b000000, 8'h10, 8'hA5, 8'h00);
    tbl[7]  = mkv(2'b10, 8'h01, 8'h00, 2'b00, 8'h00, 8'h00, 6'b001001, 8'h01, 8'hA5, 8'h00);
    tbl[8]  = mkv(2'b10, 8'h01, 8'h00, 2'b00, 8'h00, 8'h00, 6'b101000, 8'h01, 8'h11, 8'h00);
    tbl[9]  = mkv(2'b10, 8'h02, 8'h00, 2'b00, 8'h00, 8'h00, 6'b000000, 8'h01, 8'h11, 8'h00);
    tbl[10] = mkv(2'b10, 8'h02, 8'h00, 2'b00, 8'h00, 8'h00, 6'b001001, 8'h02, 8'h11, 8'h00);
    tbl[11] = mkv(2'b10, 8'h02, 8'h00, 2'b00, 8'h00, 8'h00, 6'b101000, 8'h02, 8'h22, 8'h00);
    tbl[12] = mkv(2'b00, 8'h02, 8'h00, 2'b00, 8'h00, 8'h00, 6'b000000, 8'h02, 8'h22, 8'h00);
    tbl[13] = mkv(2'b11, 8'h30, 8'h77, 2'b00, 8'h00, 8'h00, 6'b001010, 8'h30, 8'h22, 8'h00);
    tbl[14] = mkv(2'b11, 8'h31, 8'h00, 2'b11, 8'h40, 8'h99, 6'b101000, 8'h30, 8'h22, 8'h00);
    tbl[15] = mkv(2'b11, 8'h31, 8'h00, 2'b11, 8'h40, 8'h99, 6'b000000, 8'h30, 8'h22, 8'h00);
    tbl[16] = mkv(2'b00, 8'h31, 8'h00, 2'b11, 8'h40, 8'h99, 6'b001110, 8'h40, 8'h22, 8'h00);
    tbl[17] = mkv(2'b00, 8'h31, 8'h00, 2'b11, 8'h41, 8'h00, 6'b011100, 8'h40, 8'h22, 8'h00);
    tbl[18] = mkv(2'b00, 8'h31, 8'h00, 2'b11, 8'h41, 8'h00, 6'b000100, 8'h40, 8'h22, 8'h00);
    tbl[19] = mkv(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 6'b000100, 8'h40, 8'h22, 8'h00);

    nreset = 1'b0;
    {cpu_req, cpu_we, dma_req, dma_we} = 4'b0000;
    cpu_addr = 8'h00; cpu_wdata = 8'h00; dma_addr = 8'h00; dma_wdata = 8'h00;
    #7;
    chk("reset_state", 32'(outs()), 32'h0);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      {cpu_req, cpu_we} = tbl[i].cflags;
      cpu_addr  = tbl[i].caddr;
      cpu_wdata = tbl[i].cwd;
      {dma_req, dma_we} = tbl[i].dflags;
      dma_addr  = tbl[i].daddr;
      dma_wdata = tbl[i].dwd;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
    chk("mem30_cpu_write", 32'(mem[8'h30]), 32'h77);
    chk("mem31_untouched", 32'(mem[8'h31]), 32'h00);
    chk("mem40_dma_write", 32'(mem[8'h40]), 32'h99);
    chk("mem41_untouched", 32'(mem[8'h41]), 32'h00);

    // Contention: both request continuously, expect C,C,C,C,D repeating
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h02;
    for (int g = 0; g < 10; g++) begin
      wait_ack($sformatf("contend%0d", g), c, d);
      chk($sformatf("contend%0d_grant", g), 32'({c, d, owner}),
          (g % 5 == 4) ? 32'h3 : 32'h4);
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    @(posedge clk);
    #1;
    chk("contend_rdata", 32'({cpu_rdata, dma_rdata}), 32'h1122);

    // DMA write to the top address, then CPU reads it back
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'hFF; dma_wdata = 8'h3C;
    wait_ack("dma_ff", c, d);
    dma_req = 1'b0;
    chk("dma_ff_ack", 32'({c, d, owner}), 32'h3);
    chk("dma_ff_streak", 32'(dut.u_starve.streak_q), 32'h0);
    @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'hFF;
    wait_ack("cpu_ff", c, d);
    cpu_req = 1'b0;
    chk("cpu_ff_rdata", 32'({c, d, cpu_rdata}), 32'h23C);
    @(posedge clk);
    #1;

    // Reset during ACCESS of a CPU write: nothing committed, no ack
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h5A;
    @(posedge clk);
    #1;
    chk("rst_access_we", 32'({busy, ram_we}), 32'h3);
    #2;
    nreset = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk("rst_immediate", 32'(outs()), 32'h0);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_no_ack", 32'(outs()), 32'h0);
    chk("rst_mem20", 32'(mem[8'h20]), 32'h00);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    wait_ack("post_rst", c, d);
    cpu_req = 1'b0;
    chk("post_rst_read", 32'({c, d, owner, cpu_rdata}), 32'h4A5);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
